// File: rtl/ps2_rx_ctrl_if.sv
// Host-side bus of the PS/2 receiver: FIFO read port and sticky status flags.
//   rd_en      host -> rx   pop one FIFO entry this cycle
//   clr_flags  host -> rx   clear frame_err and overflow
//   rd_data    rx -> host   FIFO head, {24'b0, code}; 0 when empty
//   empty      rx -> host   FIFO holds no entries
//   full       rx -> host   FIFO holds FIFO_DEPTH entries
//   frame_err  rx -> host   sticky framing/parity/timeout error
//   overflow   rx -> host   sticky: good frame dropped on a full FIFO
interface ps2_rx_ctrl_if;
    logic        rd_en;
    logic        clr_flags;
    logic [31:0] rd_data;
    logic        empty;
    logic        full;
    logic        frame_err;
    logic        overflow;

    modport master (
        output rd_en, clr_flags,
        input  rd_data, empty, full, frame_err, overflow
    );

    modport slave (
        input  rd_en, clr_flags,
        output rd_data, empty, full, frame_err, overflow
    );
endinterface

// File: rtl/ps2_rx_ctrl.sv
// PS/2 receive controller: synchronizes and filters the raw PS/2 lines, deframes
// 11-bit frames (start, 8 data LSB-first, odd parity, stop) and buffers good
// scancodes in a small FIFO.
//   clk, rst_n  system clock, asynchronous active-low reset
//   ps2_clk     raw PS/2 clock line (asynchronous)
//   ps2_data    raw PS/2 data line (asynchronous)
//   bus         host bus (rd_en, clr_flags, rd_data, empty, full, frame_err, overflow)
module ps2_rx_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 5000,
    parameter int unsigned FIFO_DEPTH     = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           ps2_clk,
    input  logic           ps2_data,
    ps2_rx_ctrl_if.slave   bus
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam int unsigned ToW  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StData   = 2'd1;
    localparam logic [1:0] StParity = 2'd2;
    localparam logic [1:0] StStop   = 2'd3;

    // Synchronizers and clock filter
    logic       clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d;
    logic       dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;
    logic [3:0] clk_hist_q, clk_hist_d;
    logic       clk_filt_q, clk_filt_d;
    logic       fall_edge;

    // Deframer
    logic [1:0]     state_q, state_d;
    logic [2:0]     bit_cnt_q, bit_cnt_d;
    logic [7:0]     code_q, code_d;
    logic           parity_q, parity_d;
    logic [ToW-1:0] to_cnt_q, to_cnt_d;
    logic           push_q, push_d;
    logic [7:0]     push_code_q, push_code_d;
    logic           frame_err_set;

    // FIFO and flags
    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [7:0]      mem_d [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            do_push, do_pop, ovf_set;
    logic            frame_err_q, frame_err_d, overflow_q, overflow_d;

    always_comb begin
        clk_s1_d   = ps2_clk;
        clk_s2_d   = clk_s1_q;
        dat_s1_d   = ps2_data;
        dat_s2_d   = dat_s1_q;
        clk_hist_d = {clk_hist_q[2:0], clk_s2_q};
        clk_filt_d = clk_filt_q;
        if (clk_hist_q == 4'b0000) begin
            clk_filt_d = 1'b0;
        end else if (clk_hist_q == 4'b1111) begin
            clk_filt_d = 1'b1;
        end
        fall_edge = clk_filt_q & ~clk_filt_d;
    end

    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        code_d        = code_q;
        parity_d      = parity_q;
        to_cnt_d      = to_cnt_q;
        push_d        = 1'b0;
        push_code_d   = push_code_q;
        frame_err_set = 1'b0;

        unique case (state_q)
            StIdle: begin
                to_cnt_d = '0;
                if (fall_edge) begin
                    if (!dat_s2_q) begin
                        state_d   = StData;
                        bit_cnt_d = 3'd0;
                    end else begin
                        frame_err_set = 1'b1;
                    end
                end
            end
            StData: begin
                if (fall_edge) begin
                    code_d    = {dat_s2_q, code_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = StParity;
                    end
                end
            end
            StParity: begin
                if (fall_edge) begin
                    parity_d = dat_s2_q;
                    state_d  = StStop;
                end
            end
            StStop: begin
                if (fall_edge) begin
                    state_d = StIdle;
                    // Good frame: stop high and odd parity over data + parity bit
                    if (dat_s2_q && (^{code_q, parity_q})) begin
                        push_d      = 1'b1;
                        push_code_d = code_q;
                    end else begin
                        frame_err_set = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Timeout runs only inside a frame and restarts on every edge
        if (state_q != StIdle) begin
            if (fall_edge) begin
                to_cnt_d = '0;
            end else if (to_cnt_q == ToW'(TIMEOUT_CYCLES - 1)) begin
                state_d       = StIdle;
                bit_cnt_d     = 3'd0;
                code_d        = 8'd0;
                to_cnt_d      = '0;
                frame_err_set = 1'b1;
            end else begin
                to_cnt_d = to_cnt_q + ToW'(1);
            end
        end
    end

    always_comb begin
        do_pop  = bus.rd_en && (count_q != '0);
        // A pop in the same cycle frees a slot, so a push onto a full FIFO is allowed
        do_push = push_q && ((count_q != CntW'(FIFO_DEPTH)) || do_pop);
        ovf_set = push_q && !do_push;

        mem_d = mem_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_code_q;
        end
        wr_ptr_d = do_push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + PtrW'(1) : rd_ptr_q;

        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase

        // Set events take priority over clr_flags
        frame_err_d = frame_err_set ? 1'b1 : (bus.clr_flags ? 1'b0 : frame_err_q);
        overflow_d  = ovf_set       ? 1'b1 : (bus.clr_flags ? 1'b0 : overflow_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_s1_q    <= 1'b1;
            clk_s2_q    <= 1'b1;
            dat_s1_q    <= 1'b1;
            dat_s2_q    <= 1'b1;
            clk_hist_q  <= 4'b1111;
            clk_filt_q  <= 1'b1;
            state_q     <= StIdle;
            bit_cnt_q   <= 3'd0;
            code_q      <= 8'd0;
            parity_q    <= 1'b0;
            to_cnt_q    <= '0;
            push_q      <= 1'b0;
            push_code_q <= 8'd0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem_q[i] <= 8'd0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            clk_s1_q    <= clk_s1_d;
            clk_s2_q    <= clk_s2_d;
            dat_s1_q    <= dat_s1_d;
            dat_s2_q    <= dat_s2_d;
            clk_hist_q  <= clk_hist_d;
            clk_filt_q  <= clk_filt_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            code_q      <= code_d;
            parity_q    <= parity_d;
            to_cnt_q    <= to_cnt_d;
            push_q      <= push_d;
            push_code_q <= push_code_d;
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            frame_err_q <= frame_err_d;
            overflow_q  <= overflow_d;
        end
    end

    assign bus.empty     = (count_q == '0);
    assign bus.full      = (count_q == CntW'(FIFO_DEPTH));
    assign bus.rd_data   = bus.empty ? 32'd0 : {24'd0, mem_q[rd_ptr_q]};
    assign bus.frame_err = frame_err_q;
    assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_ps2_rx_ctrl.sv
// Bench for ps2_rx_ctrl: directed scenarios plus randomized frames, checked
// against a queue-based model of the scancode FIFO and the sticky flags.
module tb_ps2_rx_ctrl;

    localparam int unsigned DEPTH   = 4;
    localparam int unsigned TIMEOUT = 5000;
    localparam int          HALF    = 12;   // clk cycles per PS/2 half-bit

    logic clk = 1'b0;
    logic rst_n;
    logic ps2_clk;
    logic ps2_data;

    ps2_rx_ctrl_if bus ();

    ps2_rx_ctrl #(
        .TIMEOUT_CYCLES (TIMEOUT),
        .FIFO_DEPTH     (DEPTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int         total = 0;
    int         bad   = 0;
    logic [7:0] exp_q [$];
    bit         exp_ferr = 1'b0;
    bit         exp_ovf  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every accepted read is compared with the model head.
    always @(negedge clk) begin
        if (rst_n && bus.rd_en) begin
            if (exp_q.size() > 0) begin
                chk("pop_data", bus.rd_data, {24'd0, exp_q[0]});
                void'(exp_q.pop_front());
            end else begin
                chk("pop_when_empty_data", bus.rd_data, 32'd0);
            end
        end
    end

    // mode 0: plain bit; 1: pulse rd_en in the cycle the DUT pushes the frame;
    // 2: check the scancode is visible 2 cycles after the edge pulse.
    // The edge pulse comes 6 clk cycles after ps2_clk falls (2 sync + 4 filter).
    task automatic ps2_bit(input logic b, input int mode, input logic [7:0] code);
        @(negedge clk);
        ps2_data = b;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        if (mode == 1) begin
            repeat (7) @(posedge clk);
            #1 bus.rd_en = 1'b1;
            @(negedge clk);
            chk("full_during_swap", bus.full, 1);
            @(posedge clk);
            #1 bus.rd_en = 1'b0;
            @(negedge clk);
            chk("full_after_swap", bus.full, 1);
            repeat (HALF - 8) @(negedge clk);
        end else if (mode == 2) begin
            repeat (8) @(posedge clk);
            @(negedge clk);
            chk("latency_empty", bus.empty, 0);
            chk("latency_data", bus.rd_data, {24'd0, code});
            repeat (HALF - 9) @(negedge clk);
        end else begin
            repeat (HALF) @(negedge clk);
        end
        ps2_clk = 1'b1;
    endtask

    task automatic model_frame(input logic [7:0] code, input logic par, input logic stop);
        int ones;
        ones = par;
        for (int i = 0; i < 8; i++) ones += code[i];
        if (stop && (ones % 2 == 1)) begin
            if (exp_q.size() < DEPTH) exp_q.push_back(code);
            else exp_ovf = 1'b1;
        end else begin
            exp_ferr = 1'b1;
        end
    endtask

    task automatic send_frame(input logic [7:0] code, input bit par_flip, input logic stop,
                              input int mode);
        logic par;
        par = (~^code) ^ par_flip;
        ps2_bit(1'b0, 0, code);
        for (int i = 0; i < 8; i++) ps2_bit(code[i], 0, code);
        ps2_bit(par, 0, code);
        ps2_bit(stop, mode, code);
        repeat (HALF) @(negedge clk);
        model_frame(code, par, stop);
    endtask

    task automatic do_read();
        @(posedge clk);
        #1 bus.rd_en = 1'b1;
        @(posedge clk);
        #1 bus.rd_en = 1'b0;
    endtask

    task automatic do_clr();
        @(posedge clk);
        #1 bus.clr_flags = 1'b1;
        @(posedge clk);
        #1 bus.clr_flags = 1'b0;
        exp_ferr = 1'b0;
        exp_ovf  = 1'b0;
    endtask

    task automatic check_status(input string tag);
        @(negedge clk);
        chk({tag, "_empty"}, bus.empty, exp_q.size() == 0);
        chk({tag, "_full"}, bus.full, exp_q.size() == DEPTH);
        chk({tag, "_frame_err"}, bus.frame_err, exp_ferr);
        chk({tag, "_overflow"}, bus.overflow, exp_ovf);
        chk({tag, "_rd_data"}, bus.rd_data, (exp_q.size() > 0) ? {24'd0, exp_q[0]} : 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] code;
        int         kind;
        rst_n         = 1'b0;
        ps2_clk       = 1'b1;
        ps2_data      = 1'b1;
        bus.rd_en     = 1'b0;
        bus.clr_flags = 1'b0;
        repeat (3) @(negedge clk);
        check_status("reset");
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Single good frame, latency, read, read-while-empty ignored
        send_frame(8'h1C, 1'b0, 1'b1, 2);
        check_status("f1c");
        do_read();
        check_status("f1c_read");
        do_read();
        check_status("empty_read");

        // A lone edge with data high is a bad start bit
        ps2_bit(1'b1, 0, 8'h00);
        repeat (HALF) @(negedge clk);
        exp_ferr = 1'b1;
        check_status("bad_start");
        do_clr();
        check_status("bad_start_clr");

        // Parity error
        send_frame(8'hF0, 1'b1, 1'b1, 0);
        check_status("parity_err");
        do_clr();
        check_status("parity_clr");

        // Overflow: five frames into a four-deep FIFO
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b0, 1'b1, 0);
        check_status("overflow");
        do_clr();
        check_status("overflow_clr");

        // Full FIFO: push of 0x33 coincides with a pop
        send_frame(8'h33, 1'b0, 1'b1, 1);
        check_status("swap");
        for (int i = 0; i < DEPTH; i++) do_read();
        check_status("swap_drain");

        // Timeout mid-frame, then a good frame
        ps2_bit(1'b0, 0, 8'h00);
        for (int i = 0; i < 3; i++) ps2_bit(1'b1, 0, 8'h00);
        repeat (TIMEOUT / 2) @(negedge clk);
        check_status("pre_timeout");
        repeat (TIMEOUT) @(negedge clk);
        exp_ferr = 1'b1;
        check_status("timeout");
        send_frame(8'h5A, 1'b0, 1'b1, 0);
        check_status("after_timeout");
        do_read();
        do_clr();
        check_status("after_timeout_read");

        // Randomized frames, errors, reads and flag clears
        for (int n = 0; n < 16; n++) begin
            code = 8'($urandom);
            kind = int'($urandom_range(0, 5));
            send_frame(code, kind == 0, (kind == 1) ? 1'b0 : 1'b1, 0);
            for (int r = 0; r < int'($urandom_range(0, 2)); r++) do_read();
            if ($urandom_range(0, 3) == 0) do_clr();
            check_status("random");
        end

        // Reset in the middle of a frame, then a fresh frame
        ps2_bit(1'b0, 0, 8'h00);
        for (int i = 0; i < 5; i++) ps2_bit(1'(i % 2), 0, 8'h00);
        @(negedge clk);
        rst_n = 1'b0;
        exp_q.delete();
        exp_ferr = 1'b0;
        exp_ovf  = 1'b0;
        #1;
        chk("async_reset_empty", bus.empty, 1);
        chk("async_reset_ferr", bus.frame_err, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        send_frame(8'h29, 1'b0, 1'b1, 0);
        check_status("post_reset");
        do_read();
        check_status("post_reset_read");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ps2_rx_ctrl.md
PS2_RX_CTRL -- requirements
Module: ps2_rx_ctrl

Interface
REQ-001 TIMEOUT_CYCLES, default 5000, SHALL set the number of clk cycles without a PS/2 falling edge that aborts a frame in progress.
REQ-002 FIFO_DEPTH, default 4, SHALL set the number of scancode entries buffered; legal values are 2, 4 or 8.
REQ-003 clk  input  1  system clock; all state SHALL be on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 ps2_clk  input  1  raw PS/2 clock line, asynchronous to clk.
REQ-006 ps2_data  input  1  raw PS/2 data line, asynchronous to clk.
REQ-007 rd_en  input  1  pop one FIFO entry this cycle.
REQ-008 clr_flags  input  1  clear the sticky error flags.
REQ-009 rd_data  output  32  FIFO head scancode, zero-extended as {24'b0, code}.
REQ-010 empty  output  1  FIFO holds no entries.
REQ-011 full  output  1  FIFO holds FIFO_DEPTH entries.
REQ-012 frame_err  output  1  sticky: parity, start-bit, stop-bit or timeout error seen.
REQ-013 overflow  output  1  sticky: a good frame was dropped because the FIFO was full.

Function
REQ-014 ps2_clk and ps2_data SHALL each pass through a 2-flop synchronizer; ps2_clk SHALL additionally be filtered so that it changes only after 4 consecutive equal synchronized samples.
REQ-015 A PS/2 falling edge SHALL be a one-cycle pulse when the filtered ps2_clk goes 1->0; ps2_data SHALL be sampled on that pulse.
REQ-016 The FSM SHALL have states IDLE, DATA, PARITY and STOP, with IDLE at reset.
REQ-017 IDLE: on an edge with data=0 (start bit), go to DATA with bit count 0; on an edge with data=1, set frame_err and stay in IDLE.
REQ-018 DATA: each edge SHALL shift data into the code register LSB-first; after the 8th bit, go to PARITY.
REQ-019 PARITY: the edge SHALL capture the parity bit; go to STOP.
REQ-020 STOP: on an edge, the frame SHALL be good if stop=1 and the XOR of the 8 data bits and parity is 1 (odd parity); then return to IDLE.
REQ-021 A good frame SHALL push the code into the FIFO on the cycle after the stop edge, provided the FIFO is not full; if full, the frame is discarded and overflow is set.
REQ-022 A bad frame SHALL push nothing and SHALL set frame_err.
REQ-023 In every non-IDLE state, a timeout counter SHALL reset on each edge; reaching TIMEOUT_CYCLES SHALL force IDLE, set frame_err, and discard the partial code.
REQ-024 rd_data SHALL show the head entry combinationally; it SHALL be 0 when empty.
REQ-025 rd_en while empty SHALL be ignored, with no pointer movement and no flag change.
REQ-026 A simultaneous push and pop SHALL be honoured in the same cycle; occupancy is unchanged, and push is allowed even when full.
REQ-027 Pointers SHALL wrap modulo FIFO_DEPTH; empty/full SHALL be derived from an occupancy count of width clog2(FIFO_DEPTH)+1.
REQ-028 clr_flags SHALL clear frame_err and overflow next cycle; a set event in the same cycle SHALL win.
REQ-029 Scancode latency: the code SHALL be visible on rd_data, with empty=0, by 2 clk cycles after the stop-bit edge pulse.

Reset
REQ-030 rst_n=0 SHALL immediately force FSM=IDLE, bit count=0, timeout count=0, FIFO pointers and count=0, empty=1, full=0, frame_err=0, overflow=0, rd_data=0, and filter/synchronizer flops=1 (idle bus).
REQ-031 Reset asserted mid-frame SHALL discard the partial frame; after release, the next start bit SHALL begin a fresh frame.

Verification
REQ-032 Send frame 0x1C (start 0, bits LSB-first, parity 0, stop 1) -> empty=0 and rd_data=0x0000001C; rd_en pulse -> empty=1.
REQ-033 Send 0xF0 with parity forced to 1 -> no push, empty stays 1, frame_err=1; clr_flags -> frame_err=0.
REQ-034 Send 5 good frames 0x01..0x05 with FIFO_DEPTH=4 and no reads -> full=1, overflow=1; reads return 0x01..0x04 in order.
REQ-035 Send start bit plus 3 data bits, then hold ps2_clk high for TIMEOUT_CYCLES -> FSM back in IDLE and frame_err=1; a following good frame 0x5A is received correctly.
REQ-036 With FIFO full, the stop edge of good frame 0x33 coincides with rd_en -> head popped, 0x33 pushed, full stays 1, overflow=0.
REQ-037 Assert rst_n=0 after the 5th data bit, release, then send 0x29 -> only 0x29 is in the FIFO and frame_err=0.
